// File: rtl/vc_credit_out_stage_pkg.sv
// Shared NoC definitions for the output-port credit/launch stage: link defaults,
// counter-interface indices and the common flit/counter types.
package vc_credit_out_stage_pkg;

    localparam int          DEF_FLIT_W       = 55;
    localparam int          DEF_NUM_VC       = 2;
    localparam int          DEF_CREDIT_DEPTH = 4;
    localparam logic [7:0]  DEF_CNT_IDX_BASE = 8'h00;
    localparam logic [7:0]  CNT_IDX_STRIDE   = 8'h01;

    typedef logic [DEF_FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  idx;
    } counter_if;

    // A single-VC link still needs a one-bit select so the port exists.
    function automatic int vcWidth(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

endpackage

// File: rtl/vc_credit_out_stage_counter.sv
// Per-VC downstream credit counter: resets full, saturates at DEPTH and flags
// any credit returned to a full counter that is not offset by a consume.
module vc_credit_counter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] countReg;
    logic [CW-1:0] countNext;

    always_comb begin
        countNext = countReg;
        overflow  = 1'b0;
        if (inc && !dec) begin
            if (countReg == DEPTH_C) begin
                overflow = 1'b1;
            end else begin
                countNext = countReg + ONE_C;
            end
        end else if (dec && !inc && (countReg != '0)) begin
            countNext = countReg - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= DEPTH_C;
        end else begin
            countReg <= countNext;
        end
    end

    assign count   = countReg;
    assign nonzero = (countReg != '0);

endmodule

// File: rtl/vc_credit_out_stage.sv
// Output-port credit and launch stage: accepts flits from the switch allocator,
// launches them one cycle later only when their VC holds a downstream credit.
module vc_credit_out_stage
    import vc_credit_out_stage_pkg::*;
#(
    parameter int         FLIT_W       = DEF_FLIT_W,
    parameter int         NUM_VC       = DEF_NUM_VC,
    parameter int         CREDIT_DEPTH = DEF_CREDIT_DEPTH,
    parameter logic [7:0] CNT_IDX_BASE = DEF_CNT_IDX_BASE,
    localparam int        VC_W         = vcWidth(NUM_VC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] io_in_flit,
    input  logic [VC_W-1:0]   io_in_vc,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic [FLIT_W-1:0] io_out_flit_x,
    output logic              io_out_flitValid,
    input  logic [NUM_VC-1:0] io_out_credit_grant,
    output logic [NUM_VC-1:0] io_credit_avail,
    output logic              io_idle,
    output logic              io_err_overflow,
    output logic [31:0]       io_counters_0_counterVal,
    output logic [7:0]        io_counters_0_counterIndex,
    output logic [31:0]       io_counters_1_counterVal,
    output logic [7:0]        io_counters_1_counterIndex
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    logic [NUM_VC-1:0] vcMatch;
    logic [NUM_VC-1:0] credNonzero;
    logic [NUM_VC-1:0] credFull;
    logic [NUM_VC-1:0] credDec;
    logic [NUM_VC-1:0] credOvf;
    logic [CW-1:0]     credCount [NUM_VC];

    logic              accept;
    logic              stall;

    logic [FLIT_W-1:0] flitReg;
    logic              flitValidReg;
    logic              errOverflowReg;
    logic [31:0]       sentCountReg;
    logic [31:0]       stallCountReg;

    counter_if         sentCounter;
    counter_if         stallCounter;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : genCred
            // An out-of-range VC select matches no lane, so it is never ready.
            assign vcMatch[gi] = (io_in_vc == VC_W'(gi));
            assign credDec[gi] = accept && vcMatch[gi];

            vc_credit_counter #(
                .DEPTH (CREDIT_DEPTH),
                .CW    (CW)
            ) uCounter (
                .clk      (clk),
                .reset    (reset),
                .inc      (io_out_credit_grant[gi]),
                .dec      (credDec[gi]),
                .count    (credCount[gi]),
                .nonzero  (credNonzero[gi]),
                .overflow (credOvf[gi])
            );

            assign credFull[gi] = (credCount[gi] == CW'(CREDIT_DEPTH));
        end
    endgenerate

    // Readiness uses registered counts only; returned credits are usable next cycle.
    assign io_in_ready = |(vcMatch & credNonzero);
    assign accept      = io_in_valid && io_in_ready;
    assign stall       = io_in_valid && !io_in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flitReg        <= '0;
            flitValidReg   <= 1'b0;
            errOverflowReg <= 1'b0;
            sentCountReg   <= '0;
            stallCountReg  <= '0;
        end else begin
            flitValidReg <= accept;
            if (accept) begin
                flitReg      <= io_in_flit;
                sentCountReg <= sentCountReg + 32'd1;
            end
            if (stall) begin
                stallCountReg <= stallCountReg + 32'd1;
            end
            if (|credOvf) begin
                errOverflowReg <= 1'b1;
            end
        end
    end

    assign sentCounter  = '{val: sentCountReg,  idx: CNT_IDX_BASE};
    assign stallCounter = '{val: stallCountReg, idx: CNT_IDX_BASE + CNT_IDX_STRIDE};

    assign io_out_flit_x              = flitReg;
    assign io_out_flitValid           = flitValidReg;
    assign io_credit_avail            = credNonzero;
    assign io_idle                    = (&credFull) && !flitValidReg;
    assign io_err_overflow            = errOverflowReg;
    assign io_counters_0_counterVal   = sentCounter.val;
    assign io_counters_0_counterIndex = sentCounter.idx;
    assign io_counters_1_counterVal   = stallCounter.val;
    assign io_counters_1_counterIndex = stallCounter.idx;

endmodule

// File: tb/tb_vc_credit_out_stage.sv
// Self-checking bench for vc_credit_out_stage: a credit/queue-level reference
// model compared every cycle, plus literal expectations for directed scenarios.
module tb_vc_credit_out_stage;

    localparam int         FLIT_W = 55;
    localparam int         NUM_VC = 2;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] IDX0   = 8'h00;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [FLIT_W-1:0] io_in_flit = '0;
    logic [0:0]        io_in_vc = '0;
    logic              io_in_valid = 1'b0;
    logic              io_in_ready;
    logic [FLIT_W-1:0] io_out_flit_x;
    logic              io_out_flitValid;
    logic [NUM_VC-1:0] io_out_credit_grant = '0;
    logic [NUM_VC-1:0] io_credit_avail;
    logic              io_idle;
    logic              io_err_overflow;
    logic [31:0]       io_counters_0_counterVal;
    logic [7:0]        io_counters_0_counterIndex;
    logic [31:0]       io_counters_1_counterVal;
    logic [7:0]        io_counters_1_counterIndex;

    int checks = 0;
    int failures = 0;

    vc_credit_out_stage #(
        .FLIT_W       (FLIT_W),
        .NUM_VC       (NUM_VC),
        .CREDIT_DEPTH (DEPTH),
        .CNT_IDX_BASE (IDX0)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .io_in_flit                 (io_in_flit),
        .io_in_vc                   (io_in_vc),
        .io_in_valid                (io_in_valid),
        .io_in_ready                (io_in_ready),
        .io_out_flit_x              (io_out_flit_x),
        .io_out_flitValid           (io_out_flitValid),
        .io_out_credit_grant        (io_out_credit_grant),
        .io_credit_avail            (io_credit_avail),
        .io_idle                    (io_idle),
        .io_err_overflow            (io_err_overflow),
        .io_counters_0_counterVal   (io_counters_0_counterVal),
        .io_counters_0_counterIndex (io_counters_0_counterIndex),
        .io_counters_1_counterVal   (io_counters_1_counterVal),
        .io_counters_1_counterIndex (io_counters_1_counterIndex)
    );

    always #5 clk = ~clk;

    // Reference model: credits as plain integers, launched flit, event counts.
    int                mCred [NUM_VC] = '{DEPTH, DEPTH};
    logic [FLIT_W-1:0] mFlit  = '0;
    bit                mValid = 1'b0;
    logic [31:0]       mSent  = '0;
    logic [31:0]       mStall = '0;
    bit                mErr   = 1'b0;
    bit                mRdy;
    bit                mAcc;
    int                mDelta;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) mCred[v] = DEPTH;
            mFlit  = '0;
            mValid = 1'b0;
            mSent  = '0;
            mStall = '0;
            mErr   = 1'b0;
        end else begin
            mRdy = (int'(io_in_vc) < NUM_VC) && (mCred[io_in_vc] > 0);
            mAcc = io_in_valid && mRdy;
            for (int v = 0; v < NUM_VC; v++) begin
                mDelta = int'(io_out_credit_grant[v]) - int'(mAcc && (int'(io_in_vc) == v));
                if (mDelta == 1 && mCred[v] == DEPTH) mErr = 1'b1;
                else mCred[v] = mCred[v] + mDelta;
            end
            if (mAcc) mFlit = io_in_flit;
            mValid = mAcc;
            if (mAcc) mSent = mSent + 32'd1;
            if (io_in_valid && !mRdy) mStall = mStall + 32'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit expReady();
        return (int'(io_in_vc) < NUM_VC) && (mCred[io_in_vc] > 0);
    endfunction

    function automatic bit expIdle();
        bit full = 1'b1;
        for (int v = 0; v < NUM_VC; v++) if (mCred[v] != DEPTH) full = 1'b0;
        return full && !mValid;
    endfunction

    function automatic logic [NUM_VC-1:0] expAvail();
        logic [NUM_VC-1:0] a = '0;
        for (int v = 0; v < NUM_VC; v++) a[v] = (mCred[v] != 0);
        return a;
    endfunction

    always @(negedge clk) begin
        check("ready",     64'(io_in_ready),              64'(expReady()));
        check("flitValid", 64'(io_out_flitValid),         64'(mValid));
        check("flit",      64'(io_out_flit_x),            64'(mFlit));
        check("avail",     64'(io_credit_avail),          64'(expAvail()));
        check("idle",      64'(io_idle),                  64'(expIdle()));
        check("overflow",  64'(io_err_overflow),          64'(mErr));
        check("sent",      64'(io_counters_0_counterVal), 64'(mSent));
        check("stalls",    64'(io_counters_1_counterVal), 64'(mStall));
    end

    // Apply inputs, let one rising edge pass, return 2 time units after it.
    task automatic drive(input logic v, input logic [0:0] vc, input logic [FLIT_W-1:0] f,
                         input logic [NUM_VC-1:0] g);
        io_in_valid = v;
        io_in_vc = vc;
        io_in_flit = f;
        io_out_credit_grant = g;
        @(posedge clk);
        #2;
        $display("cyc t=%0t valid=%0b vc=%0d grant=%b -> ready=%0b outValid=%0b flit=%0h avail=%b",
                 $time, v, vc, g, io_in_ready, io_out_flitValid, io_out_flit_x, io_credit_avail);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        check("rst_ready", 64'(io_in_ready), 64'd1);
        check("rst_idle",  64'(io_idle), 64'd1);
        check("rst_avail", 64'(io_credit_avail), 64'b11);
        check("rst_idx1",  64'(io_counters_1_counterIndex), 64'h01);

        // Drain VC0 with no grants: four accepts, then two stall cycles.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, FLIT_W'(55'h100 + i), 2'b00);
        check("t1_ready", 64'(io_in_ready), 64'd0);
        check("t1_avail", 64'(io_credit_avail), 64'b10);
        check("t1_sent",  64'(io_counters_0_counterVal), 64'd4);
        check("t1_stall", 64'(io_counters_1_counterVal), 64'd2);
        check("t1_flit",  64'(io_out_flit_x), 64'h103);

        // Drain VC1, then a pending VC1 flit waits for a single returned credit.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, FLIT_W'(55'h200 + i), 2'b00);
        drive(1'b1, 1'b1, 55'h2AA, 2'b00);
        drive(1'b1, 1'b1, 55'h2AA, 2'b10);
        check("t2_ready_after_grant", 64'(io_in_ready), 64'd1);
        check("t2_no_early_launch", 64'(io_out_flitValid), 64'd0);
        drive(1'b1, 1'b1, 55'h2AA, 2'b00);
        check("t2_launch_valid", 64'(io_out_flitValid), 64'd1);
        check("t2_launch_flit",  64'(io_out_flit_x), 64'h2AA);
        drive(1'b0, 1'b0, '0, 2'b00);

        // Bring VC0 to two credits, then accept and return on VC0 together.
        drive(1'b0, 1'b0, '0, 2'b01);
        drive(1'b0, 1'b0, '0, 2'b01);
        drive(1'b1, 1'b0, 55'h300, 2'b01);
        check("t3_idle", 64'(io_idle), 64'd0);
        check("t3_valid", 64'(io_out_flitValid), 64'd1);
        for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, FLIT_W'(55'h300 + i), 2'b00);
        check("t3_avail", 64'(io_credit_avail), 64'b00);
        check("t3_sent", 64'(io_counters_0_counterVal), 64'd12);
        check("t3_flit", 64'(io_out_flit_x), 64'h302);

        // Refill both VCs together, then return one credit too many on VC0.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 2'b11);
        check("t4_idle_full", 64'(io_idle), 64'd1);
        check("t4_no_err", 64'(io_err_overflow), 64'd0);
        drive(1'b0, 1'b0, '0, 2'b01);
        check("t4_err", 64'(io_err_overflow), 64'd1);
        check("t4_still_full", 64'(io_idle), 64'd1);
        drive(1'b0, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b0, '0, 2'b00);
        check("t4_err_sticky", 64'(io_err_overflow), 64'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, FLIT_W'(55'h400 + i), 2'b00);
        check("t4_sent", 64'(io_counters_0_counterVal), 64'd16);

        // Asynchronous reset between edges while a flit is being launched.
        drive(1'b1, 1'b1, 55'h500, 2'b00);
        check("t5_inflight", 64'(io_out_flitValid), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("t5_async_valid", 64'(io_out_flitValid), 64'd0);
        check("t5_async_err",   64'(io_err_overflow), 64'd0);
        check("t5_async_sent",  64'(io_counters_0_counterVal), 64'd0);
        io_in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;

        // Sent counter wraps from all ones to zero on the next accept.
        force dut.sentCountReg = 32'hFFFF_FFFF;
        mSent = 32'hFFFF_FFFF;
        #1 release dut.sentCountReg;
        #1;
        drive(1'b1, 1'b0, 55'h600, 2'b00);
        check("t6_wrap", 64'(io_counters_0_counterVal), 64'd0);
        check("t6_idx0", 64'(io_counters_0_counterIndex), 64'(IDX0));
        drive(1'b0, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b0, '0, 2'b01);
        drive(1'b0, 1'b0, '0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
